dmem_param: RTL
===============

Name: dmem_param

Overview:
Parametrised single-port data memory for the microcontroller datapath, the successor to the fixed 8-bit data memory. Width, depth and address size are generic. Reads are registered and use a valid/ready request handshake with a response strobe. An optional post-reset clear sequencer zeroes every word, and a sticky flag records out-of-range accesses.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
CLEAR_ON_RST, 1, 1 = zero all words after reset before accepting requests; 0 = contents untouched by reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present (replaces old enable E)
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write, 0 = read; sampled on accept
req_addr  input  ADDR_W  word address; sampled on accept
req_wdata  input  DATA_W  write data; sampled on accept
rsp_valid  output  1  one-cycle strobe, response for the request accepted in the previous cycle
rsp_rdata  output  DATA_W  read data, or echoed write data; holds its value between strobes
init_done  output  1  high once the clear sequence has finished (or immediately if CLEAR_ON_RST=0)
err_oob  output  1  sticky: set when any accepted request has req_addr >= DEPTH

Behaviour:
- Reset (rst=1 at clk edge):
  - State <= CLEAR if CLEAR_ON_RST=1, else RUN.
  - clr_cnt <= 0; rsp_valid <= 0; rsp_rdata <= 0; err_oob <= 0.
  - init_done <= 0 if CLEAR_ON_RST=1, else 1.
  - Rules are identical whether reset arrives idle, mid-clear or mid-transfer.
- req_ready is combinational and equals (state==RUN && !rst).
- Accept occurs when req_valid && req_ready.
- State CLEAR:
  - Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the cycle that writes index DEPTH-1: state <= RUN and init_done <= 1.
  - Clear takes exactly DEPTH cycles after reset deasserts. Request inputs are ignored; rsp_valid stays 0.
- State RUN: no exit except rst.
- Accepted write, in range:
  - mem[addr] <= wdata at that edge.
  - Next cycle: rsp_valid=1 and rsp_rdata=wdata (write acknowledge).
- Accepted read, in range:
  - Next cycle: rsp_valid=1 and rsp_rdata=mem[addr].
  - Read latency is 1 cycle.
- Back-to-back requests are allowed every cycle, giving full throughput. There is no response back-pressure.
- Read of the address written in the immediately preceding accepted cycle returns the new data. This holds naturally because of the registered read after the write edge.
- Out-of-range access (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Write is suppressed and memory is unchanged.
  - Read returns 0.
  - rsp_valid still pulses.
  - err_oob <= 1 and stays set until rst.
- No accept in a cycle: rsp_valid <= 0 next cycle; rsp_rdata holds.
- Reset mid-operation:
  - A response due on the cycle after reset is dropped (rsp_valid=0).
  - A write accepted on the same edge as rst is not performed (req_ready was 0).
  - With CLEAR_ON_RST=1, a partial clear restarts from index 0.
- Memory contents are undefined before the first clear when CLEAR_ON_RST=0.

Test Plan:
- Config DATA_W=8, ADDR_W=4, DEPTH=12, CLEAR_ON_RST=1. Pulse rst 1 cycle, then count cycles -> req_ready=0 and init_done=0 for exactly 12 cycles, then both 1. Read addresses 0..11 -> rsp_rdata=0x00 each, one cycle after each accept.
- Write 0xA5 @3, then read @3 on the very next cycle -> rsp_valid pulses on two consecutive cycles. rsp_rdata=0xA5 (write echo), then 0xA5 (read).
- Stream 12 back-to-back writes (addr i, data 0x10+i), then 12 back-to-back reads -> 12 consecutive rsp_valid cycles returning 0x10..0x1B in order, with no bubbles.
- Write 0xFF @13 (out of range) -> rsp_valid=1, err_oob=1. Read @13 -> rsp_rdata=0x00. Read @1 -> unaffected. err_oob stays 1 until rst.
- Assert rst on cycle 5 of the clear sequence -> clear restarts, init_done rises 12 cycles after rst release. A write of 0x77 @2 issued during the clear -> ignored, read @2 returns 0x00.
- Config CLEAR_ON_RST=0: write 0x3C @7, pulse rst, read @7 -> req_ready=1 the cycle after reset. rsp_rdata=0x3C (contents retained). err_oob and rsp_rdata were 0 after reset.

Source files
------------

// File: rtl/dmem_param.sv
// Parametrised single-port data memory with a valid/ready request port, a registered
// one-cycle response, an optional post-reset zeroing sequencer and a sticky out-of-range flag.
module dmem_param #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              err_oob
);

  // Word index width; DEPTH <= 2**ADDR_W guarantees IDX_W <= ADDR_W.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              init_done_q;
  logic              err_oob_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              addr_in_range;
  logic [IDX_W-1:0]  word_idx;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

  assign req_ready     = (state_q == ST_RUN) && !rst;
  assign accept        = req_valid && req_ready;
  assign addr_in_range = {1'b0, req_addr} < DEPTH_L;
  assign word_idx      = req_addr[IDX_W-1:0];
  assign wr_en         = accept && req_we && addr_in_range;

  // Reads sample the array before this edge's write lands; a write acknowledge echoes wdata.
  always_comb begin
    rd_word     = '0;
    rsp_rdata_d = '0;
    if (addr_in_range) begin
      rd_word = mem_q[word_idx];
    end
    rsp_rdata_d = req_we ? req_wdata : rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[word_idx] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= !CLEAR_ON_RST;
      err_oob_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rdata_q <= rsp_rdata_d;
        if (!addr_in_range) begin
          err_oob_q <= 1'b1;
        end
      end
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign err_oob   = err_oob_q;

endmodule
